// File: rtl/booth_r4_encoder_seq_if.sv
// Operand/digit handshake bundle for the sequential radix-4 Booth encoder.
// The master side presents operands and consumes digits; the slave side is the encoder.
interface booth_r4_encoder_seq_if #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] mult;
  logic [2:0]       sdn;
  logic             sdn_valid;
  logic             sdn_ready;
  logic [IDXW-1:0]  sdn_idx;
  logic             sdn_last;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, mult, sdn_ready,
    input  in_ready, sdn, sdn_valid, sdn_idx, sdn_last, busy, done
  );

  modport slave (
    input  in_valid, mult, sdn_ready,
    output in_ready, sdn, sdn_valid, sdn_idx, sdn_last, busy, done
  );
endinterface

// File: rtl/booth_r4_encoder_seq.sv
// Sequential radix-4 Booth encoder: streams one {sel1, sel2, neg} code per digit,
// least-significant digit first, from a registered copy of the multiplier.
module booth_r4_encoder_seq #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  booth_r4_encoder_seq_if.slave  bus
);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("booth_r4_encoder_seq: WIDTH must be even and >= 4");
  end
  if ((2 ** IDXW) < (WIDTH / 2)) begin : g_bad_idxw
    $error("booth_r4_encoder_seq: IDXW too narrow for WIDTH/2 digits");
  end

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH / 2 - 1);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH:0]   sr;
  logic [IDXW-1:0]  idx;
  logic             done_q;
  logic             at_last;
  logic             xfer;
  logic             load;
  logic [2:0]       code;

  always_comb begin
    at_last = (idx == LAST_IDX);
    xfer    = (state == EMIT) && bus.sdn_ready;
    load    = (state == IDLE) && bus.in_valid;
  end

  // Triplet (b2i+1, b2i, b2i-1) to {sel1, sel2, neg}; 111 deliberately yields +0.
  always_comb begin
    code = 3'b000;
    case (sr[2:0])
      3'b000:  code = 3'b000;
      3'b001:  code = 3'b100;
      3'b010:  code = 3'b100;
      3'b011:  code = 3'b010;
      3'b100:  code = 3'b011;
      3'b101:  code = 3'b101;
      3'b110:  code = 3'b101;
      3'b111:  code = 3'b000;
      default: code = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load) state_nx = EMIT;
      EMIT:    if (xfer && at_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shift register and digit index; cleared after the last digit so IDLE shows idx 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr     <= '0;
      idx    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        sr  <= {bus.mult, 1'b0};
        idx <= '0;
      end else if (xfer) begin
        if (at_last) begin
          sr     <= '0;
          idx    <= '0;
          done_q <= 1'b1;
        end else begin
          sr  <= {{2{sr[WIDTH]}}, sr[WIDTH:2]};
          idx <= idx + IDXW'(1);
        end
      end
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.sdn_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.sdn       = 3'b000;
    bus.sdn_idx   = '0;
    bus.sdn_last  = 1'b0;
    bus.done      = done_q;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
      end
      EMIT: begin
        bus.sdn_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.sdn       = code;
        bus.sdn_idx   = idx;
        bus.sdn_last  = at_last;
      end
      default: begin
        bus.in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_r4_encoder_seq.sv
// Directed and randomized checks of the radix-4 Booth encoder against a digit-formula
// reference model and the digit-sum identity.
module tb_booth_r4_encoder_seq;

  localparam int W  = 8;
  localparam int IW = 2;
  localparam int N  = W / 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  booth_r4_encoder_seq_if #(.WIDTH(W), .IDXW(IW)) bus ();

  booth_r4_encoder_seq #(.WIDTH(W), .IDXW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int bitof(input int v, input int k);
    return (v >>> k) & 1;
  endfunction

  // Digit i = -2*b(2i+1) + b(2i) + b(2i-1), with b(-1) = 0.
  function automatic logic [2:0] ref_code(input logic [W-1:0] m, input int i);
    int v;
    int d;
    v = int'($signed(m));
    d = -2 * bitof(v, 2*i+1) + bitof(v, 2*i) + ((i == 0) ? 0 : bitof(v, 2*i-1));
    case (d)
      1:       return 3'b100;
      2:       return 3'b010;
      -1:      return 3'b101;
      -2:      return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int digit_of(input logic [2:0] s);
    int mag;
    mag = s[2] ? 1 : (s[1] ? 2 : 0);
    return s[0] ? -mag : mag;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    chk({tag, "_sdn_valid"}, 32'(bus.sdn_valid), 0);
    chk({tag, "_sdn"}, 32'(bus.sdn), 0);
    chk({tag, "_sdn_idx"}, 32'(bus.sdn_idx), 0);
    chk({tag, "_sdn_last"}, 32'(bus.sdn_last), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
  endtask

  task automatic load(input logic [W-1:0] m);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    chk("load_wait_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.mult     = m;
    step();
    bus.in_valid = 1'b0;
    bus.mult     = W'($urandom);
  endtask

  // Walks all digits of m; optional stall at one index, optional reset abort at one index.
  task automatic emit(input logic [W-1:0] m, input int stall_idx, input int stall_n,
                      input int abort_idx, output int edges);
    int sum;
    logic [2:0] exp;
    sum   = 0;
    edges = 0;
    for (int i = 0; i < N; i++) begin
      exp = ref_code(m, i);
      chk("sdn_valid", 32'(bus.sdn_valid), 1);
      chk("sdn", 32'(bus.sdn), 32'(exp));
      chk("sdn_idx", 32'(bus.sdn_idx), i);
      chk("sdn_last", 32'(bus.sdn_last), (i == N-1) ? 1 : 0);
      chk("in_ready_emit", 32'(bus.in_ready), 0);
      chk("busy_emit", 32'(bus.busy), 1);
      sum += digit_of(bus.sdn) * (1 << (2*i));
      if (i == abort_idx) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("abort");
        step();
        chk("abort_no_done", 32'(bus.done), 0);
        return;
      end
      if (i == stall_idx) begin
        bus.sdn_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          step();
          edges++;
          chk("hold_sdn", 32'(bus.sdn), 32'(exp));
          chk("hold_idx", 32'(bus.sdn_idx), i);
          chk("hold_valid", 32'(bus.sdn_valid), 1);
        end
        bus.sdn_ready = 1'b1;
      end
      step();
      edges++;
    end
    chk("done_pulse", 32'(bus.done), 1);
    chk("post_sdn_valid", 32'(bus.sdn_valid), 0);
    chk("post_in_ready", 32'(bus.in_ready), 1);
    chk("post_busy", 32'(bus.busy), 0);
    chk("digit_sum", sum, int'($signed(m)));
    step();
    chk("done_one_cycle", 32'(bus.done), 0);
  endtask

  initial begin
    int edges;
    logic [W-1:0] m;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mult      = '0;
    bus.sdn_ready = 1'b1;
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();
    chk_reset_vals("idle");

    load(8'h00);
    emit(8'h00, -1, 0, -1, edges);
    chk("throughput_0x00", 1 + edges, N + 1);

    load(8'h7F);
    emit(8'h7F, -1, 0, -1, edges);
    load(8'h80);
    emit(8'h80, -1, 0, -1, edges);
    load(8'h5A);
    emit(8'h5A, -1, 0, -1, edges);

    load(8'h5A);
    emit(8'h5A, 1, 3, -1, edges);
    chk("cycles_load_to_done_stall3", 1 + edges, 8);

    // Second operand held on the bus during EMIT is taken only after done.
    load(8'h5A);
    bus.in_valid = 1'b1;
    bus.mult     = 8'h7F;
    emit(8'h5A, -1, 0, -1, edges);
    bus.in_valid = 1'b0;
    emit(8'h7F, -1, 0, -1, edges);

    load(8'h5A);
    emit(8'h5A, -1, 0, 2, edges);
    load(8'h80);
    emit(8'h80, -1, 0, -1, edges);

    for (int r = 0; r < 25; r++) begin
      m = W'($urandom);
      load(m);
      emit(m, int'($urandom_range(0, N)), int'($urandom_range(1, 3)), -1, edges);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
